// File: rtl/pipeline_pkg.sv
// Shared pipeline types: writeback package, MDU result record and writeback-arbiter sizing.
package pipeline_pkg;

    typedef struct packed {
        logic        wren;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } writeback_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } mdu_result_t;

    localparam int unsigned WB_FIFO_DEPTH = 2;
    localparam int unsigned WB_MAX_WAIT   = 4;

    function automatic logic [31:0] reg_onehot(input logic [4:0] i_addr);
        return 32'(1) << i_addr;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of MDU results; exposes per-slot destinations for the pending mask.
module wb_fifo
    import pipeline_pkg::*;
#(
    parameter  int unsigned DEPTH = WB_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  mdu_result_t       i_push_data,
    input  logic              i_pop,
    output mdu_result_t       o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count,
    output logic [DEPTH*5-1:0] o_entry_addr,
    output logic [DEPTH-1:0]  o_entry_valid
);

    mdu_result_t          r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;

    // Push-while-full is excluded, so push and pop never target the same slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wptr]   <= i_push_data;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_addr[i*5 +: 5] = r_mem[i].rd_addr;
        end
    end

    assign o_head        = r_mem[r_rptr];
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_empty       = (r_count == '0);
    assign o_count       = r_count;
    assign o_entry_valid = r_valid;

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && o_full));
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(i_pop && o_empty));

endmodule

// File: rtl/wb_arbiter.sv
// Merges main-pipe writeback and buffered MDU results onto the single regfile write port.
module wb_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH    = WB_FIFO_DEPTH,
    parameter int unsigned MAX_WAIT = WB_MAX_WAIT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  writeback_t  i_pipe_wb,
    input  logic        i_mdu_valid,
    input  logic [4:0]  i_mdu_rd_addr,
    input  logic [31:0] i_mdu_rd_data,
    output logic        o_mdu_ready,
    output logic        o_pipe_stall,
    output logic [31:0] o_pending_mask,
    output writeback_t  o_wb_pkg
);

    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned AGEW = $clog2(MAX_WAIT + 1);

    mdu_result_t          w_head;
    mdu_result_t          w_push_data;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic [DEPTH*5-1:0]   w_entry_addr;
    logic [DEPTH-1:0]     w_entry_valid;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pipe_wren;
    logic                 w_drain;
    logic [31:0]          w_mask;
    writeback_t           w_sel;

    logic [AGEW-1:0]      r_age;
    writeback_t           r_wb_pkg;

    // x0 destinations are architectural no-ops: MDU ones are acked but dropped.
    assign w_pipe_wren = i_pipe_wb.wren && (i_pipe_wb.rd_addr != 5'd0);
    assign w_push      = i_mdu_valid && !w_full && (i_mdu_rd_addr != 5'd0);
    assign w_push_data = '{rd_addr: i_mdu_rd_addr, rd_data: i_mdu_rd_data};
    assign w_drain     = (w_count != '0) && (r_age == AGEW'(MAX_WAIT));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_push        (w_push),
        .i_push_data   (w_push_data),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (w_count),
        .o_entry_addr  (w_entry_addr),
        .o_entry_valid (w_entry_valid)
    );

    always_comb begin
        w_sel = '0;
        w_pop = 1'b0;
        if (w_drain) begin
            w_pop = 1'b1;
            w_sel = '{wren: 1'b1, rd_addr: w_head.rd_addr, rd_data: w_head.rd_data};
        end else if (w_pipe_wren) begin
            w_sel = i_pipe_wb;
        end else if (w_count != '0) begin
            w_pop = 1'b1;
            w_sel = '{wren: 1'b1, rd_addr: w_head.rd_addr, rd_data: w_head.rd_data};
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_mask = w_mask | reg_onehot(w_entry_addr[i*5 +: 5]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_age    <= '0;
            r_wb_pkg <= '0;
        end else begin
            r_wb_pkg <= w_sel;
            if (w_pop || w_empty) begin
                r_age <= '0;
            end else if (r_age != AGEW'(MAX_WAIT)) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    assign o_mdu_ready    = !w_full;
    assign o_pipe_stall   = w_drain;
    assign o_pending_mask = w_mask;
    assign o_wb_pkg       = r_wb_pkg;

    a_wb_no_x0: assert property (@(posedge i_clk) disable iff (i_rst)
        o_wb_pkg.wren |-> (o_wb_pkg.rd_addr != 5'd0));
    a_no_waw: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_pipe_wren && w_mask[i_pipe_wb.rd_addr]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    writeback_t  pipe_wb = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd_addr = '0;
    logic [31:0] mdu_rd_data = '0;
    logic        mdu_ready;
    logic        pipe_stall;
    logic [31:0] pending_mask;
    writeback_t  wb_pkg;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pipe_wb      (pipe_wb),
        .i_mdu_valid    (mdu_valid),
        .i_mdu_rd_addr  (mdu_rd_addr),
        .i_mdu_rd_data  (mdu_rd_data),
        .o_mdu_ready    (mdu_ready),
        .o_pipe_stall   (pipe_stall),
        .o_pending_mask (pending_mask),
        .o_wb_pkg       (wb_pkg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic wren, input logic [4:0] rd,
                          input logic [31:0] data);
        n_cmp++;
        assert (wb_pkg === {wren, rd, data}) else begin
            n_bad++;
            $error("FAIL %s observed=%b/%0d/%h expected=%b/%0d/%h", tag, wb_pkg.wren,
                   wb_pkg.rd_addr, wb_pkg.rd_data, wren, rd, data);
        end
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] data);
        mdu_valid   = v;
        mdu_rd_addr = rd;
        mdu_rd_data = data;
    endtask

    task automatic pipe(input logic wren, input logic [4:0] rd, input logic [31:0] data);
        pipe_wb = '{wren: wren, rd_addr: rd, rd_data: data};
    endtask

    initial begin
        // Reset state
        #12;
        chk_wb("rst_wb", 1'b0, 5'd0, 32'h0);
        chk1("rst_ready", mdu_ready, 1'b1);
        chk1("rst_stall", pipe_stall, 1'b0);
        chk32("rst_mask", pending_mask, 32'h0);
        rst = 1'b0;

        // Pipe only
        pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk_wb("pipe_x5", 1'b1, 5'd5, 32'hDEADBEEF);
        pipe(1'b1, 5'd0, 32'h1234);
        tick();
        chk1("pipe_x0_wren", wb_pkg.wren, 1'b0);
        pipe(1'b0, 5'd0, 32'h0);

        // MDU through idle pipe
        mdu(1'b1, 5'd7, 32'h2A);
        tick();
        chk32("mdu7_mask", pending_mask, 32'h80);
        chk1("mdu7_wb_idle", wb_pkg.wren, 1'b0);
        mdu(1'b0, 5'd0, 32'h0);
        tick();
        chk_wb("mdu7_wb", 1'b1, 5'd7, 32'h2A);
        chk32("mdu7_mask_clr", pending_mask, 32'h0);

        // MDU x0 is acked but not enqueued
        mdu(1'b1, 5'd0, 32'h99);
        chk1("mdu_x0_ready", mdu_ready, 1'b1);
        tick();
        chk32("mdu_x0_mask", pending_mask, 32'h0);
        mdu(1'b0, 5'd0, 32'h0);
        tick();
        chk1("mdu_x0_nowb", wb_pkg.wren, 1'b0);

        // Starvation: busy pipe, MDU x9 forced through after four waits
        pipe(1'b1, 5'd3, 32'h100);
        mdu(1'b1, 5'd9, 32'h11);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        chk_wb("starve_p0", 1'b1, 5'd3, 32'h100);
        chk1("starve_nostall0", pipe_stall, 1'b0);
        pipe(1'b1, 5'd3, 32'h101);
        tick();
        chk_wb("starve_p1", 1'b1, 5'd3, 32'h101);
        pipe(1'b1, 5'd3, 32'h102);
        tick();
        chk1("starve_nostall2", pipe_stall, 1'b0);
        pipe(1'b1, 5'd3, 32'h103);
        tick();
        chk1("starve_nostall3", pipe_stall, 1'b0);
        pipe(1'b1, 5'd3, 32'h104);
        tick();
        chk_wb("starve_p4", 1'b1, 5'd3, 32'h104);
        chk1("starve_stall", pipe_stall, 1'b1);
        pipe(1'b1, 5'd3, 32'h105);
        tick();
        chk_wb("starve_drain", 1'b1, 5'd9, 32'h11);
        chk1("starve_stall_once", pipe_stall, 1'b0);
        chk32("starve_mask", pending_mask, 32'h0);
        tick();
        chk_wb("starve_held", 1'b1, 5'd3, 32'h105);
        pipe(1'b1, 5'd3, 32'h106);
        tick();
        chk_wb("starve_next", 1'b1, 5'd3, 32'h106);

        // Full FIFO with busy pipe
        pipe(1'b1, 5'd3, 32'h55);
        mdu(1'b1, 5'd1, 32'hA);
        tick();
        mdu(1'b1, 5'd2, 32'hB);
        tick();
        chk1("full_ready", mdu_ready, 1'b0);
        chk32("full_mask", pending_mask, 32'h6);
        mdu(1'b1, 5'd8, 32'hC);
        tick();
        tick();
        chk1("full_wait_ready", mdu_ready, 1'b0);
        tick();
        chk1("full_stall", pipe_stall, 1'b1);
        chk_wb("full_pipe", 1'b1, 5'd3, 32'h55);
        pipe(1'b1, 5'd3, 32'h66);
        tick();
        chk_wb("full_pop1", 1'b1, 5'd1, 32'hA);
        chk1("full_ready_back", mdu_ready, 1'b1);
        chk32("full_mask_pop1", pending_mask, 32'h4);
        tick();
        chk_wb("full_held", 1'b1, 5'd3, 32'h66);
        chk32("full_mask_push3", pending_mask, 32'h104);
        mdu(1'b0, 5'd0, 32'h0);
        pipe(1'b0, 5'd0, 32'h0);
        tick();
        chk_wb("full_pop2", 1'b1, 5'd2, 32'hB);
        chk32("full_mask_pop2", pending_mask, 32'h100);
        tick();
        chk_wb("full_pop3", 1'b1, 5'd8, 32'hC);
        chk32("full_mask_empty", pending_mask, 32'h0);

        // Duplicate destination with push and pop on the same edge
        mdu(1'b1, 5'd4, 32'h1);
        tick();
        chk32("dup_mask0", pending_mask, 32'h10);
        mdu(1'b1, 5'd4, 32'h2);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        chk_wb("dup_wb1", 1'b1, 5'd4, 32'h1);
        chk32("dup_mask1", pending_mask, 32'h10);
        tick();
        chk_wb("dup_wb2", 1'b1, 5'd4, 32'h2);
        chk32("dup_mask2", pending_mask, 32'h0);

        // Async reset with two entries queued
        pipe(1'b1, 5'd3, 32'h77);
        mdu(1'b1, 5'd10, 32'h10);
        tick();
        mdu(1'b1, 5'd11, 32'h11);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        chk32("prerst_mask", pending_mask, 32'hC00);
        chk1("prerst_ready", mdu_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_wb("arst_wb", 1'b0, 5'd0, 32'h0);
        chk1("arst_ready", mdu_ready, 1'b1);
        chk32("arst_mask", pending_mask, 32'h0);
        chk1("arst_stall", pipe_stall, 1'b0);
        pipe(1'b0, 5'd0, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk1("postrst_nowb", wb_pkg.wren, 1'b0);
        tick();
        chk1("postrst_nowb2", wb_pkg.wren, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
